// File: rtl/burst_ram_pkg.sv
// Shared types for burst_ram: FSM state, operation kind and the counter-width helper.
package burst_ram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_TRANSFER,
    ST_DONE,
    ST_ERROR
  } state_e;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_e;

  // Bits needed to hold (n - 1); never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/burst_ram_if.sv
// Request/response bus of burst_ram.
//   master drives: address, readEnabled, writeEnabled, burst, dataOut
//   slave drives : dataIn, wordValid, functionComplete, error
interface burst_ram_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32
);
  logic [ADDRESS_WIDTH-1:0] address;
  logic                     readEnabled;
  logic                     writeEnabled;
  logic                     burst;
  logic [DATA_WIDTH-1:0]    dataOut;
  logic [DATA_WIDTH-1:0]    dataIn;
  logic                     wordValid;
  logic                     functionComplete;
  logic                     error;

  modport master (
    output address, readEnabled, writeEnabled, burst, dataOut,
    input  dataIn, wordValid, functionComplete, error
  );

  modport slave (
    input  address, readEnabled, writeEnabled, burst, dataOut,
    output dataIn, wordValid, functionComplete, error
  );
endinterface

// File: rtl/burst_ram_access_delay_counter.sv
// access_delay_counter: loadable down-counter timing the WAIT phase.
//   clock, reset : clock and synchronous active-high reset
//   load         : load load_value
//   load_value   : initial count
//   dec          : decrement (saturates at zero)
//   zero_c       : count is zero once this cycle's decrement has been applied
module access_delay_counter #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero_c
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  // Look-ahead so the FSM leaves WAIT on the cycle the count reaches zero.
  assign zero_c = (count_q == '0) || (dec && (count_q == WIDTH'(1)));

endmodule

// File: rtl/burst_ram.sv
// burst_ram: word RAM with fixed access latency and optional whole-block bursts.
//   clock : sole clock, rising edge
//   reset : synchronous active-high reset (memory contents are kept)
//   bus   : burst_ram_if slave (request in, read data / strobes out)
// Build option: define BURST_RAM_BURST_EN to honour bus.burst; otherwise every
// request is a single word at its own (unaligned) address.
module burst_ram
  import burst_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned ADDRESS_WIDTH    = 32,
  parameter int unsigned NUMBER_OF_BLOCKS = 128,
  parameter int unsigned WORDS_PER_BLOCK  = 8,
  parameter int unsigned DELAY            = 4,
  parameter string       INIT_FILE        = ""
) (
  input  logic        clock,
  input  logic        reset,
  burst_ram_if.slave  bus
);

  localparam int unsigned SIZE     = NUMBER_OF_BLOCKS * WORDS_PER_BLOCK;
  localparam int unsigned MEM_AW   = cnt_width(SIZE);
  localparam int unsigned DLY_W    = cnt_width(DELAY + 1);
  localparam bit          HAS_INIT = (INIT_FILE != "");

  logic [DATA_WIDTH-1:0] mem [SIZE];

  state_e                   state_q, state_d;
  op_e                      op_q, req_op_c, cur_op_c;
  logic [ADDRESS_WIDTH-1:0] addr_q, req_addr_c, beat_addr_c;
  logic [MEM_AW-1:0]        mem_idx_c;
  logic                     req_c, range_err_c, beat_last_c, dly_zero_c;
  logic [DATA_WIDTH-1:0]    data_in_q;
  logic                     word_valid_q, word_valid_d;
  logic                     complete_q, complete_d;
  logic                     error_q, error_d;
  logic                     unused_ok;

  assign req_c       = bus.readEnabled | bus.writeEnabled;
  assign req_op_c    = bus.writeEnabled ? OP_WRITE : OP_READ;
  assign range_err_c = 64'(bus.address) >= 64'(SIZE);
  assign cur_op_c    = (state_q == ST_IDLE) ? req_op_c : op_q;

`ifdef BURST_RAM_BURST_EN
  localparam int unsigned BEAT_W = cnt_width(WORDS_PER_BLOCK);

  logic              burst_q;
  logic [BEAT_W-1:0] beat_q;

  assign req_addr_c  = bus.burst ? (bus.address & ~ADDRESS_WIDTH'(WORDS_PER_BLOCK - 1))
                                 : bus.address;
  assign beat_addr_c = addr_q + ADDRESS_WIDTH'(beat_q);
  assign beat_last_c = !burst_q || (beat_q == BEAT_W'(WORDS_PER_BLOCK - 1));
  assign unused_ok   = ^{beat_addr_c, HAS_INIT};

  // Burst flag and beat index; the index restarts whenever the FSM is idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      burst_q <= 1'b0;
      beat_q  <= '0;
    end else begin
      if (state_q == ST_IDLE) begin
        burst_q <= bus.burst;
        beat_q  <= '0;
      end else if ((state_q == ST_TRANSFER) && !beat_last_c) begin
        beat_q <= beat_q + BEAT_W'(1);
      end
    end
  end
`else
  assign req_addr_c  = bus.address;
  assign beat_addr_c = addr_q;
  assign beat_last_c = 1'b1;
  assign unused_ok   = ^{beat_addr_c, bus.burst, HAS_INIT};
`endif

  assign mem_idx_c = MEM_AW'(beat_addr_c);

  access_delay_counter #(
    .WIDTH (DLY_W)
  ) u_delay (
    .clock      (clock),
    .reset      (reset),
    .load       ((state_q == ST_IDLE) && req_c && !range_err_c),
    .load_value (DLY_W'(DELAY)),
    .dec        (state_q == ST_WAIT),
    .zero_c     (dly_zero_c)
  );

  // Next state and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          if (range_err_c)     state_d = ST_ERROR;
          else if (DELAY == 0) state_d = ST_TRANSFER;
          else                 state_d = ST_WAIT;
        end
      end
      ST_WAIT:     if (dly_zero_c) state_d = ST_TRANSFER;
      ST_TRANSFER: if (beat_last_c) state_d = ST_DONE;
      ST_DONE,
      ST_ERROR:    if (!req_c) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    // Write strobes coincide with the TRANSFER cycle; read strobes follow it.
    word_valid_d = ((state_d == ST_TRANSFER) && (cur_op_c == OP_WRITE)) ||
                   ((state_q == ST_TRANSFER) && (op_q == OP_READ));
    complete_d   = (state_d == ST_DONE) || (state_d == ST_ERROR);
    error_d      = (state_d == ST_ERROR);
  end

  // State, request latch and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_READ;
      addr_q       <= '0;
      data_in_q    <= '0;
      word_valid_q <= 1'b0;
      complete_q   <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_valid_q <= word_valid_d;
      complete_q   <= complete_d;
      error_q      <= error_d;
      if (state_q == ST_IDLE) begin
        op_q   <= req_op_c;
        addr_q <= req_addr_c;
      end
      if ((state_q == ST_TRANSFER) && (op_q == OP_READ)) begin
        data_in_q <= mem[mem_idx_c];
      end
    end
  end

  // Array writes ignore reset so beats completed before a reset persist.
  always_ff @(posedge clock) begin
    if ((state_q == ST_TRANSFER) && (op_q == OP_WRITE)) begin
      mem[mem_idx_c] <= bus.dataOut;
    end
  end

  assign bus.dataIn           = data_in_q;
  assign bus.wordValid        = word_valid_q;
  assign bus.functionComplete = complete_q;
  assign bus.error            = error_q;

endmodule

// File: tb/tb_burst_ram.sv
// Bench for burst_ram: two instances (DELAY=4 and DELAY=0), scoreboard queues
// filled by the stimulus and drained by a negedge monitor.
module tb_burst_ram;

`ifdef BURST_RAM_BURST_EN
  localparam bit BURST_ON = 1'b1;
`else
  localparam bit BURST_ON = 1'b0;
`endif

  typedef enum int {EV_RD, EV_WR, EV_DONE, EV_ERR} kind_e;
  typedef struct {
    int          cyc;
    kind_e       kind;
    logic [31:0] data;
  } ev_t;
  typedef logic [31:0] vec_t [8];

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  ev_t  q0 [$];
  ev_t  q1 [$];
  logic fc_prev [2] = '{1'b0, 1'b0};
  vec_t d;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  burst_ram_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus0 ();
  burst_ram_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus1 ();

  burst_ram #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .NUMBER_OF_BLOCKS(128),
    .WORDS_PER_BLOCK(8), .DELAY(4), .INIT_FILE("")
  ) dut0 (.clock(clock), .reset(reset), .bus(bus0));

  burst_ram #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .NUMBER_OF_BLOCKS(128),
    .WORDS_PER_BLOCK(8), .DELAY(0), .INIT_FILE("")
  ) dut1 (.clock(clock), .reset(reset), .bus(bus1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input ev_t e);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic pop(input int k, output ev_t e, output bit ok);
    ok = 1'b0;
    if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
    if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
  endtask

  task automatic drive(input int k, input logic rd, input logic wr, input logic bst,
                       input logic [31:0] addr, input logic [31:0] dout);
    if (k == 0) begin
      bus0.readEnabled = rd; bus0.writeEnabled = wr; bus0.burst = bst;
      bus0.address = addr; bus0.dataOut = dout;
    end else begin
      bus1.readEnabled = rd; bus1.writeEnabled = wr; bus1.burst = bst;
      bus1.address = addr; bus1.dataOut = dout;
    end
  endtask

  // Compare one DUT's strobes with the front of its expectation queue.
  task automatic mon(input int k, input logic wv, input logic fc, input logic er,
                     input logic [31:0] din);
    ev_t e;
    bit  ok;
    if (wv) begin
      pop(k, e, ok);
      check($sformatf("dut%0d_beat_expected", k), 32'(ok && (e.kind == EV_RD || e.kind == EV_WR)), 32'd1);
      if (ok) begin
        check($sformatf("dut%0d_beat_cycle", k), 32'(cyc), 32'(e.cyc));
        if (e.kind == EV_RD) check($sformatf("dut%0d_read_data", k), din, e.data);
      end
    end
    if (fc && !fc_prev[k]) begin
      pop(k, e, ok);
      check($sformatf("dut%0d_complete_expected", k), 32'(ok && (e.kind == EV_DONE || e.kind == EV_ERR)), 32'd1);
      if (ok) begin
        check($sformatf("dut%0d_complete_cycle", k), 32'(cyc), 32'(e.cyc));
        check($sformatf("dut%0d_error_flag", k), 32'(er), 32'(e.kind == EV_ERR));
      end
    end
    fc_prev[k] = fc;
  endtask

  always @(negedge clock) begin
    mon(0, bus0.wordValid, bus0.functionComplete, bus0.error, bus0.dataIn);
    mon(1, bus1.wordValid, bus1.functionComplete, bus1.error, bus1.dataIn);
  end

  task automatic check_idle_outputs(input int k, input string tag);
    if (k == 0) begin
      check({tag, "_dataIn"}, bus0.dataIn, 32'd0);
      check({tag, "_wordValid"}, 32'(bus0.wordValid), 32'd0);
      check({tag, "_functionComplete"}, 32'(bus0.functionComplete), 32'd0);
      check({tag, "_error"}, 32'(bus0.error), 32'd0);
    end else begin
      check({tag, "_dataIn"}, bus1.dataIn, 32'd0);
      check({tag, "_wordValid"}, 32'(bus1.wordValid), 32'd0);
      check({tag, "_functionComplete"}, 32'(bus1.functionComplete), 32'd0);
      check({tag, "_error"}, 32'(bus1.error), 32'd0);
    end
  endtask

  // One request issued at the current negedge. Expected events are queued from
  // hand-derived offsets: write beat i at DELAY+1+i, read beat i at DELAY+2+i,
  // completion at DELAY+beats+1, error completion at 1. A non-negative rst_at
  // pulses reset in that relative cycle; events after it are not expected.
  task automatic do_op(input int k, input logic rd, input logic wr, input logic bst,
                       input int addr, input vec_t v, input int rst_at);
    int  dly   = (k == 0) ? 4 : 0;
    int  beats = (bst && BURST_ON) ? 8 : 1;
    bit  err   = (addr >= 1024);
    int  n0    = cyc;
    int  last  = err ? 1 : dly + beats + 1;
    int  off;
    ev_t e;
    if (err) begin
      e = '{cyc: n0 + 1, kind: EV_ERR, data: 32'd0};
      if (rst_at < 0 || 1 <= rst_at) push(k, e);
    end else begin
      for (int i = 0; i < beats; i++) begin
        off = wr ? dly + 1 + i : dly + 2 + i;
        e = '{cyc: n0 + off, kind: (wr ? EV_WR : EV_RD), data: v[i]};
        if (rst_at < 0 || off <= rst_at) push(k, e);
      end
      e = '{cyc: n0 + last, kind: EV_DONE, data: 32'd0};
      if (rst_at < 0 || last <= rst_at) push(k, e);
    end
    drive(k, rd, wr, bst, 32'(addr), v[0]);
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge clock);
      drive(k, 1'b0, 1'b0, bst, 32'(addr),
            (wr && c >= dly + 1 && c < dly + 1 + beats) ? v[c - dly - 1] : v[0]);
      if (c == rst_at) reset = 1'b1;
      if (c == rst_at + 1) begin
        reset = 1'b0;
        check_idle_outputs(k, "after_reset");
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required finished");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_idle_outputs(0, "reset0");
    check_idle_outputs(1, "reset1");

    // Single write then read with DELAY=4.
    d = '{32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0};
    do_op(0, 1'b0, 1'b1, 1'b0, 5, d, -1);
    do_op(0, 1'b1, 1'b0, 1'b0, 5, d, -1);

    // Both enables: write wins.
    d = '{32'h55, 0, 0, 0, 0, 0, 0, 0};
    do_op(0, 1'b1, 1'b1, 1'b0, 3, d, -1);
    do_op(0, 1'b1, 1'b0, 1'b0, 3, d, -1);

    // Burst write at 19 (block base 16).
    d = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
    do_op(0, 1'b0, 1'b1, 1'b1, 19, d, -1);
`ifdef BURST_RAM_BURST_EN
    do_op(0, 1'b1, 1'b0, 1'b1, 16, d, -1);
`else
    do_op(0, 1'b1, 1'b0, 1'b1, 19, d, -1);
`endif

    // Out-of-range read and write; word 5 must be unchanged.
    d = '{32'h12345678, 0, 0, 0, 0, 0, 0, 0};
    do_op(0, 1'b1, 1'b0, 1'b0, 1024, d, -1);
    do_op(0, 1'b0, 1'b1, 1'b0, 1029, d, -1);
    d = '{32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0};
    do_op(0, 1'b1, 1'b0, 1'b0, 5, d, -1);

    // Reset in the middle of an access.
`ifdef BURST_RAM_BURST_EN
    d = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hA7};
    do_op(0, 1'b0, 1'b1, 1'b1, 32, d, -1);
    d = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5, 32'hB6, 32'hB7};
    do_op(0, 1'b0, 1'b1, 1'b1, 35, d, 7);
    d = '{32'hB0, 32'hB1, 32'hB2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hA7};
    do_op(0, 1'b1, 1'b0, 1'b1, 32, d, -1);
`else
    d = '{32'hA0, 0, 0, 0, 0, 0, 0, 0};
    do_op(0, 1'b0, 1'b1, 1'b0, 40, d, -1);
    d = '{32'hB0, 0, 0, 0, 0, 0, 0, 0};
    do_op(0, 1'b0, 1'b1, 1'b0, 40, d, 2);
    d = '{32'hA0, 0, 0, 0, 0, 0, 0, 0};
    do_op(0, 1'b1, 1'b0, 1'b0, 40, d, -1);
`endif

    // Zero-latency instance.
    d = '{32'h0C0FFEE0, 0, 0, 0, 0, 0, 0, 0};
    do_op(1, 1'b0, 1'b1, 1'b0, 7, d, -1);
    do_op(1, 1'b1, 1'b0, 1'b0, 7, d, -1);

    repeat (3) @(negedge clock);
    check("dut0_queue_drained", 32'(q0.size()), 32'd0);
    check("dut1_queue_drained", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
